instr_exec_unit: RTL

Downstream consumer of the instruction register. On a start command it walks the register's read port from a programmed first address for a programmed count of entries, sampling each `instruction_word`. It evaluates the opcode on the two operands and delivers one result per instruction on a valid/ready output stream, honouring backpressure. It sits between the instruction register and the result checker/scoreboard stage.

---
 rtl/instr_register_pkg.sv | 33 +++
 rtl/instr_alu.sv | 35 +++
 rtl/instr_exec_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its downstream execution unit.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        OUT   = 2'd3
    } exec_state_t;

    localparam int MAX_COUNT = 32;

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode evaluator: signed operands, result truncated to operand width.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opcode,
    input  operand_t a,
    input  operand_t b,
    output operand_t result,
    output logic     div_zero
);

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a;
            PASSB: result = b;
            ADD:   result = a + b;
            SUB:   result = a - b;
            MULT:  result = a * b;
            // A zero divisor still yields a delivered result, flagged instead of computed.
            DIV: begin
                if (b == '0) div_zero = 1'b1;
                else         result   = a / b;
            end
            MOD: begin
                if (b == '0) div_zero = 1'b1;
                else         result   = a % b;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Walks the instruction register read port and streams one ALU result per entry
// on a valid/ready interface with backpressure.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int MAX_COUNT = 32
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     first_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         res_valid,
    input  logic         res_ready,
    output operand_t     res_data,
    output address_t     res_addr,
    output logic         div_zero,
    output logic         busy,
    output logic         done
);

    localparam logic [5:0] MAX_W = 6'(MAX_COUNT);

    exec_state_t  state_reg;
    address_t     read_pointer_reg;
    address_t     instr_addr_reg;
    address_t     res_addr_reg;
    instruction_t instr_reg;
    logic [5:0]   remaining_reg;
    operand_t     res_data_reg;
    logic         res_valid_reg;
    logic         div_zero_reg;
    logic         busy_reg;
    logic         done_reg;

    operand_t     alu_result;
    logic         alu_div_zero;
    logic [5:0]   count_eff;

    instr_alu u_alu (
        .opcode   (instr_reg.opc),
        .a        (instr_reg.op_a),
        .b        (instr_reg.op_b),
        .result   (alu_result),
        .div_zero (alu_div_zero)
    );

    // A zero count still processes one entry; oversize counts clamp to the register depth.
    always_comb begin
        count_eff = count;
        if (count == 6'd0)      count_eff = 6'd1;
        else if (count > MAX_W) count_eff = MAX_W;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            read_pointer_reg <= '0;
            instr_addr_reg   <= '0;
            res_addr_reg     <= '0;
            instr_reg        <= '0;
            remaining_reg    <= '0;
            res_data_reg     <= '0;
            res_valid_reg    <= 1'b0;
            div_zero_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        read_pointer_reg <= first_addr;
                        remaining_reg    <= count_eff;
                        busy_reg         <= 1'b1;
                        state_reg        <= FETCH;
                    end
                end
                FETCH: begin
                    instr_reg      <= instruction_word;
                    instr_addr_reg <= read_pointer_reg;
                    state_reg      <= EXEC;
                end
                EXEC: begin
                    res_data_reg  <= alu_result;
                    res_addr_reg  <= instr_addr_reg;
                    div_zero_reg  <= alu_div_zero;
                    res_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        remaining_reg <= remaining_reg - 6'd1;
                        if (remaining_reg == 6'd1) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            read_pointer_reg <= read_pointer_reg + 5'd1;
                            state_reg        <= FETCH;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign read_pointer = read_pointer_reg;
    assign res_valid    = res_valid_reg;
    assign res_data     = res_data_reg;
    assign res_addr     = res_addr_reg;
    assign div_zero     = div_zero_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule
